// File: rtl/strob_gen.sv
// strob_gen: two-phase CPU strobe sequencer (strob1_, optional strob2_, got).
// Define STROB_STEP_EN to add panel single-step HOLD after each got pulse.
module strob_gen #(
    parameter int STROB_LEN = 2,
    parameter int GAP       = 1
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic go,
    input  logic sl,
    input  logic wb,
    input  logic bus_ok,
    input  logic step,
    output logic strob1_,
    output logic strob2_,
    output logic got,
    output logic busy
);

    localparam int MAXC = (STROB_LEN > GAP) ? STROB_LEN : GAP;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] LEN_M1 = CW'(STROB_LEN - 1);
    localparam logic [CW-1:0] GAP_M1 = CW'(GAP - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXC - 1);

    typedef enum logic [2:0] {
        IDLE,
        S1,
        G1,
        WB,
        S2,
`ifdef STROB_STEP_EN
        HOLD,
`endif
        GOT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sl_q, sl_d;
    logic          wb_q, wb_d;
    logic          ok_q, ok_d;
    logic          s1_q, s2_q, got_q, busy_q;

`ifdef STROB_STEP_EN
    logic ss_q, ss_d;
    logic step_q;
`else
    logic unused_step;
    assign unused_step = step;
`endif

    always_comb begin
        state_d = state_q;
        sl_d    = sl_q;
        wb_d    = wb_q;
        ok_d    = ok_q;
`ifdef STROB_STEP_EN
        ss_d    = ss_q;
`endif
        case (state_q)
            IDLE: begin
                if (go) begin
                    sl_d    = sl;
                    wb_d    = wb;
                    ok_d    = 1'b0;
                    state_d = S1;
`ifdef STROB_STEP_EN
                    ss_d    = step;
`endif
                end
            end
            S1: begin
                ok_d = ok_q | bus_ok;
                if (cnt_q == LEN_M1) state_d = G1;
            end
            G1: begin
                ok_d = ok_q | bus_ok;
                if (cnt_q == GAP_M1) begin
                    if (!sl_q)
                        state_d = GOT;
                    else if (wb_q && !(ok_q | bus_ok))
                        state_d = WB;
                    else
                        state_d = S2;
                end
            end
            WB: begin
                if (bus_ok) state_d = S2;
            end
            S2: begin
                if (cnt_q == LEN_M1) state_d = GOT;
            end
            GOT: begin
`ifdef STROB_STEP_EN
                state_d = ss_q ? HOLD : IDLE;
`else
                state_d = IDLE;
`endif
            end
`ifdef STROB_STEP_EN
            HOLD: begin
                if (step && !step_q) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Counter saturates so long WB/IDLE dwell never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sl_q    <= 1'b0;
            wb_q    <= 1'b0;
            ok_q    <= 1'b0;
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            got_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sl_q    <= sl_d;
            wb_q    <= wb_d;
            ok_q    <= ok_d;
            s1_q    <= (state_d != S1);
            s2_q    <= (state_d != S2);
            got_q   <= (state_d == GOT);
            busy_q  <= (state_d != IDLE);
        end
    end

`ifdef STROB_STEP_EN
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            ss_q   <= 1'b0;
            step_q <= 1'b0;
        end else begin
            ss_q   <= ss_d;
            step_q <= step;
        end
    end
`endif

    assign strob1_ = s1_q;
    assign strob2_ = s2_q;
    assign got     = got_q;
    assign busy    = busy_q;

endmodule
